// File: rtl/seg_pkg.sv
// Shared display-path definitions: digit width, blank code and converter states.
package seg_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } bcd_state_e;

  // True when `digits` decimal digits can hold every value of a `data_w`-bit word.
  function automatic bit digits_fit(input int unsigned data_w, input int unsigned digits);
    logic [255:0] p10;
    logic [255:0] max_val;
    p10 = 256'(1);
    for (int unsigned i = 0; i < digits; i++) begin
      p10 = p10 * 256'(10);
    end
    max_val = (256'(1) << data_w) - 256'(1);
    return (p10 > max_val);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble per-digit correction: nibbles of 5 or more get +3 before the shift.
module bcd_add3
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout_c
);

  // Correct a single BCD digit.
  always_comb begin
    dout_c = din;
    if (din >= DIGIT_W'(5)) begin
      dout_c = din + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
module seq_bin2bcd
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W   = 29,
  parameter int unsigned DIGITS   = 9,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      busy,
  output logic                      done,
  output logic                      neg,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  if (!digits_fit(DATA_W, DIGITS)) begin : g_bad_digits
    $error("seq_bin2bcd: DIGITS too small to represent a DATA_W-bit value");
  end

  bcd_state_e         state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               busy_d, done_d, neg_d;
  logic [BCD_W-1:0]   bcd_d;

  logic               in_neg_c;
  logic [DATA_W-1:0]  mag_c;
  logic [BCD_W-1:0]   bcd_corr_c;
  logic [BCD_W-1:0]   bcd_field_c;
  logic [BCD_W-1:0]   blank_c;
  logic [SR_W-1:0]    shift_c;
  logic               lead_c;

  // Per-digit add-3 correction of the BCD field of the scratch register.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_add3 u_add3 (
      .din    (sr_q[DATA_W + DIGIT_W*g +: DIGIT_W]),
      .dout_c (bcd_corr_c[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Input magnitude; negation in DATA_W unsigned bits also covers the most negative value.
  always_comb begin
    in_neg_c = (SIGNED != 0) && data_in[DATA_W-1];
    mag_c    = in_neg_c ? DATA_W'(~data_in + DATA_W'(1)) : data_in;
  end

  // Corrected BCD field and remaining binary bits move left by one.
  always_comb begin
    shift_c = {bcd_corr_c, sr_q[DATA_W-1:0]} << 1;
  end

  // Leading-zero blanking: digits above the most significant nonzero one become blank.
  always_comb begin
    bcd_field_c = sr_q[SR_W-1:DATA_W];
    blank_c     = bcd_field_c;
    lead_c      = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (lead_c && (bcd_field_c[DIGIT_W*i +: DIGIT_W] == '0)) begin
        blank_c[DIGIT_W*i +: DIGIT_W] = BCD_BLANK;
      end else begin
        lead_c = 1'b0;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    busy_d  = busy;
    done_d  = 1'b0;
    neg_d   = neg;
    bcd_d   = bcd_out;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, mag_c};
          sign_d  = in_neg_c;
          cnt_d   = CNT_W'(DATA_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = shift_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bcd_d   = (BLANK_LZ != 0) ? blank_c : bcd_field_c;
        neg_d   = sign_q && (bcd_field_c != '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      bcd_out <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      busy    <= busy_d;
      done    <= done_d;
      neg     <= neg_d;
      bcd_out <= bcd_d;
    end
  end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench: default converter plus BLANK_LZ=0 and SIGNED=0 variants on shared stimulus.
module tb_seq_bin2bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [28:0] data_in;

  logic        busy_a, done_a, neg_a;
  logic        busy_b, done_b, neg_b;
  logic        busy_c, done_c, neg_c;
  logic [35:0] bcd_a, bcd_b, bcd_c;

  int errs;
  int checks;

  seq_bin2bcd dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy_a), .done(done_a), .neg(neg_a), .bcd_out(bcd_a)
  );

  seq_bin2bcd #(.BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy_b), .done(done_b), .neg(neg_b), .bcd_out(bcd_b)
  );

  seq_bin2bcd #(.SIGNED(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy_c), .done(done_c), .neg(neg_c), .bcd_out(bcd_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one start at the next edge (E0) and watch 40 edges.
  // lat = index k of the first edge E_k whose pre-edge sample shows done high.
  task automatic run_conv(input logic [28:0] val, output int lat,
                          output int busy_cnt, output int done_cnt);
    data_in = val;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    int ndone, unstable;
    logic [35:0] prev, rec1, rec2, rec3;

    errs = 0;
    checks = 0;
    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 36'(busy_a), 36'(0));
    chk("rst_done", 36'(done_a), 36'(0));
    chk("rst_neg", 36'(neg_a), 36'(0));
    chk("rst_bcd_blank", bcd_a, 36'h000000000);
    chk("rst_bcd_noblank", bcd_b, 36'h000000000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero
    run_conv(29'd0, lat, bcnt, dcnt);
    chk("zero_latency", 36'(lat), 36'(31));
    chk("zero_busy_cycles", 36'(bcnt), 36'(30));
    chk("zero_done_cycles", 36'(dcnt), 36'(1));
    chk("zero_bcd_blank", bcd_a, 36'hFFFFFFFF0);
    chk("zero_neg", 36'(neg_a), 36'(0));
    chk("zero_bcd_noblank", bcd_b, 36'h000000000);

    // 255
    run_conv(29'd255, lat, bcnt, dcnt);
    chk("v255_bcd", bcd_a, 36'hFFFFFF255);
    chk("v255_neg", 36'(neg_a), 36'(0));
    chk("v255_bcd_noblank", bcd_b, 36'h000000255);

    // -1 signed, 536870911 unsigned
    run_conv(29'h1FFFFFFF, lat, bcnt, dcnt);
    chk("m1_bcd", bcd_a, 36'hFFFFFFFF1);
    chk("m1_neg", 36'(neg_a), 36'(1));
    chk("m1_bcd_noblank", bcd_b, 36'h000000001);
    chk("umax_bcd", bcd_c, 36'h536870911);
    chk("umax_neg", 36'(neg_c), 36'(0));
    chk("umax_busy_cycles", 36'(bcnt), 36'(30));
    chk("umax_done_cycles", 36'(dcnt), 36'(1));

    // Most negative value
    run_conv(29'h10000000, lat, bcnt, dcnt);
    chk("mneg_bcd", bcd_a, 36'h268435456);
    chk("mneg_neg", 36'(neg_a), 36'(1));
    chk("mneg_unsigned_bcd", bcd_c, 36'h268435456);
    chk("mneg_unsigned_neg", 36'(neg_c), 36'(0));

    // Start held high, data changing every cycle: accepts at E0, E31, E62
    ndone = 0;
    unstable = 0;
    rec1 = '0;
    rec2 = '0;
    rec3 = '0;
    prev = bcd_a;
    for (int c = 0; c <= 70; c++) begin
      data_in = 29'(1000 + c);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (done_a) begin
        ndone++;
        if (ndone == 1) rec1 = bcd_a;
        if (ndone == 2) rec2 = bcd_a;
      end else if (bcd_a !== prev) begin
        unstable++;
      end
      prev = bcd_a;
    end
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_a && rec3 == '0) rec3 = bcd_a;
    end
    chk("hold_done_count", 36'(ndone), 36'(2));
    chk("hold_first", rec1, 36'hFFFFF1000);
    chk("hold_second", rec2, 36'hFFFFF1031);
    chk("hold_third", rec3, 36'hFFFFF1062);
    chk("hold_stable", 36'(unstable), 36'(0));

    // Reset after 10 shifts of 12345
    data_in = 29'd12345;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_busy_before", 36'(busy_a), 36'(1));
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 36'(busy_a), 36'(0));
    chk("midrst_done", 36'(done_a), 36'(0));
    chk("midrst_bcd", bcd_a, 36'h000000000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_a) dcnt++;
      if (busy_a) bcnt++;
    end
    chk("midrst_no_done", 36'(dcnt), 36'(0));
    chk("midrst_no_busy", 36'(bcnt), 36'(0));
    run_conv(29'd678, lat, bcnt, dcnt);
    chk("post_rst_bcd", bcd_a, 36'hFFFFFF678);
    chk("post_rst_latency", 36'(lat), 36'(31));

    // Back-to-back: 99 at E0, 100 at E31
    data_in = 29'd99;
    start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    rec1 = '0;
    rec2 = '0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 31) begin
        data_in = 29'd100;
        start = 1'b1;
      end else begin
        data_in = 29'(k * 7919);
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_a) begin
        ndone++;
        if (ndone == 1) rec1 = bcd_a;
        if (ndone == 2) rec2 = bcd_a;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 36'(ndone), 36'(2));
    chk("b2b_first", rec1, 36'hFFFFFFF99);
    chk("b2b_second", rec2, 36'hFFFFFF100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
